// File: rtl/interlock_arbiter.sv
// -----------------------------------------------------------------------------
// interlock_arbiter
//
// Gives the single airlock chamber, and the one countdown timer that goes with
// it, to either the arriving-sequence FSM or the leaving-sequence FSM. Only one
// sequencer owns the chamber at a time. A ports-closed dead time (RELEASE)
// separates consecutive owners. Only the owner may start the timer. The timer
// counts down on a 1 Hz single-cycle enable (tick).
//
// Optional build macro: INTERLOCK_WATCHDOG_EN
//   When defined, a hold counter limits one ownership to HOLD_MAX ticks. When
//   the limit is reached the chamber is forced into RELEASE and a sticky fault
//   is raised. While fault is set no new grant is issued; only rst clears it.
//   When not defined, fault is tied low and ownership lasts until req drops.
//
// Parameters
//   TIMER_W   width of timer length and remaining count
//   HOLD_MAX  watchdog tick limit (present only with INTERLOCK_WATCHDOG_EN)
//
// Ports
//   clock          system clock
//   rst            synchronous active-high reset
//   tick           1 Hz single-cycle enable
//   inner_port     inner door open
//   outer_port     outer door open
//   arr_req        arriving sequencer requests the chamber (level)
//   lv_req         leaving sequencer requests the chamber (level)
//   arr_tmr_start  arriving sequencer timer load strobe
//   arr_tmr_len    arriving timer length in ticks
//   lv_tmr_start   leaving sequencer timer load strobe
//   lv_tmr_len     leaving timer length in ticks
//   arr_gnt        chamber granted to the arriving sequencer
//   lv_gnt         chamber granted to the leaving sequencer
//   tmr_busy       timer counting
//   tmr_done       one-cycle pulse on timer expiry
//   tmr_remain     ticks remaining
//   fault          sticky watchdog fault
// -----------------------------------------------------------------------------
module interlock_arbiter #(
    parameter int TIMER_W = 4
`ifdef INTERLOCK_WATCHDOG_EN
    ,
    parameter int HOLD_MAX = 15
`endif
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               tick,
    input  logic               inner_port,
    input  logic               outer_port,
    input  logic               arr_req,
    input  logic               lv_req,
    input  logic               arr_tmr_start,
    input  logic [TIMER_W-1:0] arr_tmr_len,
    input  logic               lv_tmr_start,
    input  logic [TIMER_W-1:0] lv_tmr_len,
    output logic               arr_gnt,
    output logic               lv_gnt,
    output logic               tmr_busy,
    output logic               tmr_done,
    output logic [TIMER_W-1:0] tmr_remain,
    output logic               fault
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_GRANT_ARR = 2'd1,
        S_GRANT_LV  = 2'd2,
        S_RELEASE   = 2'd3
    } state_t;

    state_t r_state;
    // 1 when the leaving side was the last one served. Reset value 1 makes
    // the arriving side win the first tie.
    logic   r_last_lv;

    logic               w_ports_closed;
    logic               w_grant_ok;
    logic               w_own_req;
    logic               w_own_start;
    logic [TIMER_W-1:0] w_own_len;
    logic               w_hold_expire;

`ifdef INTERLOCK_WATCHDOG_EN
    localparam int HOLD_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

    logic              r_fault;
    logic [HOLD_W-1:0] r_hold;

    // Expires on the tick that would bring the hold count up to the limit.
    assign w_hold_expire = tick && (r_hold == HOLD_LIM - 1'b1);
    assign w_grant_ok    = w_ports_closed && !r_fault;
    assign fault         = r_fault;
`else
    assign w_hold_expire = 1'b0;
    assign w_grant_ok    = w_ports_closed;
    assign fault         = 1'b0;
`endif

    assign w_ports_closed = !inner_port && !outer_port;

    // Route the owner's request and timer controls; the non-owner's strobes
    // never reach the timer.
    always_comb begin
        w_own_req   = 1'b0;
        w_own_start = 1'b0;
        w_own_len   = '0;
        if (r_state == S_GRANT_ARR) begin
            w_own_req   = arr_req;
            w_own_start = arr_tmr_start;
            w_own_len   = arr_tmr_len;
        end else if (r_state == S_GRANT_LV) begin
            w_own_req   = lv_req;
            w_own_start = lv_tmr_start;
            w_own_len   = lv_tmr_len;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last_lv  <= 1'b1;
            arr_gnt    <= 1'b0;
            lv_gnt     <= 1'b0;
            tmr_busy   <= 1'b0;
            tmr_done   <= 1'b0;
            tmr_remain <= '0;
`ifdef INTERLOCK_WATCHDOG_EN
            r_fault    <= 1'b0;
            r_hold     <= '0;
`endif
        end else begin
            tmr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ok) begin
                        if (arr_req && (!lv_req || r_last_lv)) begin
                            r_state   <= S_GRANT_ARR;
                            arr_gnt   <= 1'b1;
                            r_last_lv <= 1'b0;
                        end else if (lv_req) begin
                            r_state   <= S_GRANT_LV;
                            lv_gnt    <= 1'b1;
                            r_last_lv <= 1'b1;
                        end
`ifdef INTERLOCK_WATCHDOG_EN
                        r_hold <= '0;
`endif
                    end
                end

                S_GRANT_ARR, S_GRANT_LV: begin
                    if (!w_own_req || w_hold_expire) begin
                        // Leaving ownership always clears the timer.
                        r_state    <= S_RELEASE;
                        arr_gnt    <= 1'b0;
                        lv_gnt     <= 1'b0;
                        tmr_busy   <= 1'b0;
                        tmr_remain <= '0;
`ifdef INTERLOCK_WATCHDOG_EN
                        if (w_hold_expire) begin
                            r_fault <= 1'b1;
                        end
`endif
                    end else begin
                        // A load takes priority over a same-cycle tick.
                        if (w_own_start) begin
                            tmr_remain <= w_own_len;
                            tmr_busy   <= (w_own_len != '0);
                            tmr_done   <= (w_own_len == '0);
                        end else if (tick && tmr_busy) begin
                            tmr_remain <= tmr_remain - 1'b1;
                            if (tmr_remain == TIMER_W'(1)) begin
                                tmr_busy <= 1'b0;
                                tmr_done <= 1'b1;
                            end
                        end
`ifdef INTERLOCK_WATCHDOG_EN
                        if (tick) begin
                            r_hold <= r_hold + 1'b1;
                        end
`endif
                    end
                end

                S_RELEASE: begin
                    // Dead time: at least one cycle, and both doors shut.
                    if (w_ports_closed) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
